// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pwm_pkg
// Brief    : Shared widths, reset duty and state encoding for the PWM blocks.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  localparam int PWM_DUTY_W     = 3;
  localparam int PWM_RATE_W     = 8;
  localparam int PWM_RESET_DUTY = 4;
  localparam int DUTY_MAX       = (1 << PWM_DUTY_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int duty_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : pwm_tick_divider
// Brief    : Counts period ticks up to a terminal value and pulses step_en.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_tick_divider
  import pwm_pkg::*;
#(
  parameter int RATE_W = PWM_RATE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              tick,
  input  logic [RATE_W-1:0] term,
  output logic              step_en
);

  logic [RATE_W-1:0] cnt_q, cnt_d;

  // >= lets a terminal value lowered mid-count fire on the very next tick
  assign step_en = en && tick && (cnt_q >= term);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && tick) begin
      cnt_d = step_en ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_sequencer
// Brief    : Ramps the PWM generator duty to a target, one inc/dec pulse per
//            programmable number of PWM periods; keeps a shadow of the duty.
// Options  : PWM_SEQ_FAULT_EN adds a level fault input that ramps duty to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int                DUTY_W     = PWM_DUTY_W,
  parameter int                RATE_W     = PWM_RATE_W,
  parameter logic [DUTY_W-1:0] RESET_DUTY = DUTY_W'(PWM_RESET_DUTY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [RATE_W-1:0] rate_div,
  input  logic              period_tick,
`ifdef PWM_SEQ_FAULT_EN
  input  logic              fault,
`endif
  output logic              duty_inc,
  output logic              duty_dec,
  output logic [DUTY_W-1:0] cur_duty,
  output logic              busy,
  output logic              done
);

  localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(duty_max(DUTY_W));

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [DUTY_W-1:0] eff_tgt;
  logic [RATE_W-1:0] eff_rate;
  logic              fault_in;
  logic              div_clear, div_en, step_en;
  logic              step_any;

`ifdef PWM_SEQ_FAULT_EN
  assign fault_in = fault;
`else
  assign fault_in = 1'b0;
`endif

  // A live fault overrides the latched target immediately, even inside STEP
  assign eff_tgt  = fault_in ? '0 : tgt_q;
  assign eff_rate = fault_in ? '0 : rate_q;
  assign cur_duty = cur_q;

  pwm_tick_divider #(
    .RATE_W (RATE_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .clear   (div_clear),
    .en      (div_en),
    .tick    (period_tick),
    .term    (eff_rate),
    .step_en (step_en)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    rate_d    = rate_q;
    tgt_ready = 1'b0;
    duty_inc  = 1'b0;
    duty_dec  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    div_clear = 1'b0;
    div_en    = 1'b0;
    step_any  = 1'b0;

    case (state_q)
      IDLE: begin
        tgt_ready = !fault_in;
        if (fault_in && (cur_q != '0)) begin
          div_clear = 1'b1;
          state_d   = RAMP;
        end else if (tgt_valid && tgt_ready) begin
          tgt_d     = tgt_duty;
          rate_d    = rate_div;
          div_clear = 1'b1;
          state_d   = (tgt_duty == cur_q) ? DONE : RAMP;
        end
      end
      RAMP: begin
        busy   = 1'b1;
        div_en = 1'b1;
        if (step_en) begin
          state_d = STEP;
        end
      end
      STEP: begin
        busy = 1'b1;
        if ((eff_tgt > cur_q) && (cur_q != DUTY_TOP)) begin
          duty_inc = 1'b1;
          step_any = 1'b1;
          cur_d    = cur_q + 1'b1;
        end else if ((eff_tgt < cur_q) && (cur_q != '0)) begin
          duty_dec = 1'b1;
          step_any = 1'b1;
          cur_d    = cur_q - 1'b1;
        end
        // No legal step means we are already there (or saturated): finish
        state_d = ((cur_d == eff_tgt) || !step_any) ? DONE : RAMP;
      end
      DONE: begin
        done    = 1'b1;
        state_d = (fault_in && (cur_q != '0)) ? RAMP : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fault_in) begin
      tgt_d  = '0;
      rate_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= RESET_DUTY;
      tgt_q   <= RESET_DUTY;
      rate_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_sequencer
// Brief    : Self-checking bench with a tick-counting reference model.
// Options  : PWM_SEQ_FAULT_EN enables the fault ramp-down scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_sequencer;

  localparam int DW = 3;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tgt_valid = 1'b0;
  logic [DW-1:0] tgt_duty = '0;
  logic [RW-1:0] rate_div = '0;
  logic          period_tick = 1'b0;
  logic          tgt_ready, duty_inc, duty_dec, busy, done;
  logic [DW-1:0] cur_duty;
`ifdef PWM_SEQ_FAULT_EN
  logic          fault = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a ramp is a count of ticks since acceptance; the k-th
  // step lands one cycle after tick number k*(rate+1).
  int m_cur = 4, m_tgt = 4, m_rate = 0, m_ticks = 0;
  bit m_ramp = 0, m_step = 0, m_done = 0, m_acc = 0;
  bit model_on = 1;
  int cyc = 0, last_done_cyc = -10, acc_cyc = 0;
  int tick_gap = 3;
  bit prev_tick = 0;
  int gen_duty = 4;
  int n_inc = 0, n_dec = 0, n_done = 0, n_busy = 0;

  always #5 clk = ~clk;

  pwm_duty_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .tgt_valid   (tgt_valid),
    .tgt_ready   (tgt_ready),
    .tgt_duty    (tgt_duty),
    .rate_div    (rate_div),
    .period_tick (period_tick),
`ifdef PWM_SEQ_FAULT_EN
    .fault       (fault),
`endif
    .duty_inc    (duty_inc),
    .duty_dec    (duty_dec),
    .cur_duty    (cur_duty),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic cycle();
    if (tick_gap == 0) begin
      period_tick = 1'b1;
      tick_gap    = $urandom_range(5, 2);
    end else begin
      period_tick = 1'b0;
      tick_gap--;
    end
    #4;
    if (model_on) begin
      chk("cur_duty",  32'(cur_duty),  32'(m_cur));
      chk("duty_inc",  32'(duty_inc),  32'(m_step && (m_tgt > m_cur)));
      chk("duty_dec",  32'(duty_dec),  32'(m_step && (m_tgt < m_cur)));
      chk("busy",      32'(busy),      32'(m_ramp));
      chk("done",      32'(done),      32'(m_done));
      chk("tgt_ready", 32'(tgt_ready), 32'(!m_ramp && !m_done));
    end
`ifdef PWM_SEQ_FAULT_EN
    else begin
      if (fault) chk("fault_ready_low", 32'(tgt_ready), 32'(0));
      if (duty_dec) chk("fault_dec_after_tick", 32'(prev_tick), 32'(1));
    end
`endif
    if (duty_inc) begin n_inc++; if (gen_duty < 7) gen_duty++; end
    if (duty_dec) begin n_dec++; if (gen_duty > 0) gen_duty--; end
    if (done) n_done++;
    if (busy) n_busy++;

    m_acc = 0;
    if (m_step) begin
      m_cur  = (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
      m_step = 0;
      if (m_cur == m_tgt) begin m_ramp = 0; m_done = 1; end
    end else if (m_done) begin
      m_done = 0;
      last_done_cyc = cyc;
    end else if (m_ramp) begin
      if (period_tick) begin
        m_ticks++;
        if (m_ticks % (m_rate + 1) == 0) m_step = 1;
      end
    end else if (tgt_valid) begin
      m_acc   = 1;
      acc_cyc = cyc;
      m_tgt   = int'(tgt_duty);
      m_rate  = int'(rate_div);
      m_ticks = 0;
      if (m_tgt == m_cur) m_done = 1; else m_ramp = 1;
    end
    prev_tick = period_tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int t, input int r);
    int budget;
    budget    = 0;
    tgt_valid = 1'b1;
    tgt_duty  = DW'(t);
    rate_div  = RW'(r);
    do begin cycle(); budget++; end while (!m_acc && budget < 3000);
    tgt_valid = 1'b0;
    if (!m_acc) chk("accept_timeout", 32'(m_acc), 32'(1));
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((m_ramp || m_step || m_done) && budget < 3000) begin cycle(); budget++; end
    if (m_ramp || m_step || m_done) chk("idle_timeout", 32'(m_ramp), 32'(0));
  endtask

  task automatic clr_counts();
    n_inc = 0; n_dec = 0; n_done = 0; n_busy = 0;
  endtask

  initial begin
    int b;
    @(posedge clk); #1;
    chk("rst_cur",   32'(cur_duty),  32'(4));
    chk("rst_ready", 32'(tgt_ready), 32'(1));
    chk("rst_busy",  32'(busy),      32'(0));
    chk("rst_pulse", 32'({duty_inc, duty_dec, done}), 32'(0));
    rst = 1'b1;
    repeat (3) cycle();

    // Up ramp 4 -> 7, one step per tick
    clr_counts();
    send(7, 0); wait_idle();
    chk("up_incs", 32'(n_inc), 32'(3));
    chk("up_done", 32'(n_done), 32'(1));
    chk("up_gen",  32'(gen_duty), 32'(7));

    // Down ramp 7 -> 1, one step per three ticks
    clr_counts();
    send(1, 2); wait_idle();
    chk("down_decs", 32'(n_dec), 32'(6));
    chk("down_incs", 32'(n_inc), 32'(0));
    chk("down_gen",  32'(gen_duty), 32'(1));

    // Equal target: immediate done, never busy
    clr_counts();
    send(1, 0); wait_idle();
    chk("eq_steps", 32'(n_inc + n_dec), 32'(0));
    chk("eq_busy",  32'(n_busy), 32'(0));
    chk("eq_done",  32'(n_done), 32'(1));
    chk("eq_lat",   32'(last_done_cyc - acc_cyc), 32'(1));

    // Hold-off: a new target offered mid-ramp waits for the first IDLE cycle
    send(5, 1);
    repeat (4) cycle();
    send(2, 0);
    chk("holdoff_accept", 32'(acc_cyc), 32'(last_done_cyc + 1));
    wait_idle();
    chk("holdoff_gen", 32'(gen_duty), 32'(2));

    // Asynchronous reset in the middle of a ramp
    send(7, 3);
    repeat (10) cycle();
    #2; rst = 1'b0; #1;
    chk("arst_cur",   32'(cur_duty),  32'(4));
    chk("arst_ready", 32'(tgt_ready), 32'(1));
    chk("arst_busy",  32'(busy),      32'(0));
    chk("arst_pulse", 32'({duty_inc, duty_dec, done}), 32'(0));
    m_cur = 4; m_tgt = 4; m_ramp = 0; m_step = 0; m_done = 0; gen_duty = 4;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();

    // Randomized ramps
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(3, 0)) cycle();
      send(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)));
      wait_idle();
      chk("rand_gen", 32'(gen_duty), 32'(m_cur));
    end

`ifdef PWM_SEQ_FAULT_EN
    send(3, 0); wait_idle();
    send(7, 0);
    b = 0;
    while (m_cur != 5 && b < 500) begin cycle(); b++; end
    model_on = 0;
    fault    = 1'b1;
    clr_counts();
    b = 0;
    while (cur_duty !== '0 && b < 500) begin cycle(); b++; end
    repeat (3) cycle();
    chk("fault_decs", 32'(n_dec),    32'(5));
    chk("fault_incs", 32'(n_inc),    32'(0));
    chk("fault_done", 32'(n_done),   32'(1));
    chk("fault_cur",  32'(cur_duty), 32'(0));
    chk("fault_gen",  32'(gen_duty), 32'(0));
    fault = 1'b0;
    #4;
    chk("fault_release_ready", 32'(tgt_ready), 32'(1));
    @(posedge clk); #1;
`else
    b = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
